port_reader: RTL

PORT_READER -- requirements
Module: port_reader

---
 rtl/port_reader_if.sv | 27 ++
 rtl/port_reader.sv | 118 +++++++++++
 2 files changed

// File: rtl/port_reader_if.sv
// Bundle between a node and its four neighbour ports: the node-side read
// request, the per-neighbour valid/data/ack lines, and the read results.
interface port_reader_if #(
  parameter int WIDTH = 11
);
  logic                    clk_en;
  logic                    rd_req;
  logic [2:0]              rd_sel;
  logic [3:0]              in_valid;
  logic [4*WIDTH-1:0]      in_data;
  logic [3:0]              in_ack;
  logic signed [WIDTH-1:0] rd_data;
  logic                    rd_done;
  logic                    busy;
  logic [2:0]              last_port;

  // Node and neighbours drive requests and words; the reader answers.
  modport master (
    output clk_en, rd_req, rd_sel, in_valid, in_data,
    input  in_ack, rd_data, rd_done, busy, last_port
  );

  modport slave (
    input  clk_en, rd_req, rd_sel, in_valid, in_data,
    output in_ack, rd_data, rd_done, busy, last_port
  );
endinterface

// File: rtl/port_reader.sv
// Blocking single-word reader for a node with four neighbour ports.
// A request resolves its source (fixed port, ANY, LAST or NIL), then waits
// in WAIT until the target has a word, consumes exactly one port and
// returns the word. ANY picks LEFT > RIGHT > UP > DOWN and remembers the
// chosen port for later LAST reads.
module port_reader #(
  parameter int WIDTH = 11
) (
  input  logic        clk,
  input  logic        reset,
  port_reader_if.slave bus
);

  localparam logic [2:0] SEL_ANY   = 3'd4;
  localparam logic [2:0] SEL_LAST  = 3'd5;
  localparam logic [2:0] PORT_NONE = 3'd7;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              target_q, target_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic [2:0]              last_q, last_d;
  logic [3:0]              ack_q, ack_d;
  logic                    done_q, done_d;

  logic [2:0]              resolved;
  logic [1:0]              port_sel;
  logic                    hit;

  // ANY arbitration: LEFT(2) > RIGHT(3) > UP(0) > DOWN(1).
  function automatic logic [1:0] any_pick(input logic [3:0] v);
    if (v[2])      return 2'd2;
    else if (v[3]) return 2'd3;
    else if (v[0]) return 2'd0;
    else           return 2'd1;
  endfunction

  // Extract the signed word of one neighbour from the packed data bus.
  function automatic logic signed [WIDTH-1:0] port_word(
    input logic [4*WIDTH-1:0] d,
    input logic [1:0]         p
  );
    return $signed(d[int'(p)*WIDTH +: WIDTH]);
  endfunction

  // State and result registers; strobes default low every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= 3'd0;
      data_q   <= '0;
      last_q   <= PORT_NONE;
      ack_q    <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      data_q   <= data_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end

  // Source resolution, completion test and next-state/strobe decode.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    data_d   = data_q;
    last_d   = last_q;
    ack_d    = 4'b0000;
    done_d   = 1'b0;
    resolved = (bus.rd_sel == SEL_LAST) ? last_q : bus.rd_sel;

    if (target_q == SEL_ANY) begin
      hit      = |bus.in_valid;
      port_sel = any_pick(bus.in_valid);
    end else begin
      hit      = bus.in_valid[target_q[1:0]];
      port_sel = target_q[1:0];
    end

    if (bus.clk_en) begin
      case (state_q)
        IDLE: begin
          if (bus.rd_req) begin
            if (resolved <= SEL_ANY) begin
              target_d = resolved;
              state_d  = WAIT;
            end else begin
              // NIL source (including LAST with no remembered port).
              data_d = '0;
              done_d = 1'b1;
            end
          end
        end
        WAIT: begin
          if (hit) begin
            data_d  = port_word(bus.in_data, port_sel);
            ack_d   = 4'b0001 << port_sel;
            done_d  = 1'b1;
            state_d = IDLE;
            if (target_q == SEL_ANY) last_d = {1'b0, port_sel};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ack    = ack_q;
  assign bus.rd_data   = data_q;
  assign bus.rd_done   = done_q;
  assign bus.busy      = (state_q == WAIT);
  assign bus.last_port = last_q;

endmodule
